nios2_mult_pipe: RTL

NIOS2_MULT_PIPE -- requirements
Module: nios2_mult_pipe

---
 rtl/nios2_mult_pkg.sv | 28 ++
 rtl/nios2_mult_pp16.sv | 42 ++++
 rtl/nios2_mult_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_mult_pkg.sv
// -----------------------------------------------------------------------------
// nios2_mult_pkg
// Shared definitions for the pipelined Nios II style multiplier:
//   - mult_mode_e : result selection / signedness encoding
//   - PIPE_DEPTH  : number of register stages between accept and result
//   - PP_W        : width of one partial-product operand slice
//   - width_is_legal() : elaboration-time check of the operand width
// -----------------------------------------------------------------------------
package nios2_mult_pkg;

  // Result selection: low half, or high half with the given operand signedness
  // (SS = A signed, B signed; SU = A signed, B unsigned; UU = both unsigned).
  typedef enum logic [1:0] {
    MODE_LO    = 2'd0,
    MODE_HI_SS = 2'd1,
    MODE_HI_SU = 2'd2,
    MODE_HI_UU = 2'd3
  } mult_mode_e;

  localparam int unsigned PIPE_DEPTH = 32'd3;
  localparam int unsigned PP_W       = 32'd16;

  // Operand widths the partial-product array supports.
  function automatic bit width_is_legal(input int unsigned w);
    return (w == 32'd16) || (w == 32'd32) || (w == 32'd48) || (w == 32'd64);
  endfunction

endpackage : nios2_mult_pkg

// File: rtl/nios2_mult_pp16.sv
// -----------------------------------------------------------------------------
// nios2_mult_pp16
// Registered 16x16 unsigned multiplier with load enable. The product register
// has no reset: it only carries data whose validity is tracked elsewhere.
// Ports:
//   clk : clock, rising edge
//   en  : load enable (low = hold current product)
//   a   : 16-bit unsigned operand
//   b   : 16-bit unsigned operand
//   p   : registered 32-bit product
// -----------------------------------------------------------------------------
module nios2_mult_pp16
  import nios2_mult_pkg::*;
(
  input  logic                clk,
  input  logic                en,
  input  logic [PP_W-1:0]     a,
  input  logic [PP_W-1:0]     b,
  output logic [2*PP_W-1:0]   p
);

  logic [2*PP_W-1:0] p_d;
  logic [2*PP_W-1:0] p_q;

  // Next product: new multiply when enabled, otherwise hold.
  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = a * b;
    end else begin
      p_d = p_q;
    end
  end

  // Product register.
  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p = p_q;

endmodule : nios2_mult_pp16

// File: rtl/nios2_mult_pipe.sv
// -----------------------------------------------------------------------------
// nios2_mult_pipe
// Three-stage pipelined WIDTH x WIDTH multiplier returning either the low half
// of the product or the high half for signed/unsigned operand combinations.
//   S1 : operand / mode / tag register
//   S2 : (WIDTH/16)^2 registered 16x16 unsigned partial products
//   S3 : sum, signedness correction and half selection -> output register
// A single global stall (out_valid && !out_ready) freezes every stage; flush
// clears all stage valid bits and wins over a stall.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready   : operation handshake
//   in_src1, in_src2      : operands A, B
//   in_mode               : mult_mode_e encoding
//   in_tag                : destination tag, returned with the result
//   flush                 : drop every in-flight operation
//   out_valid / out_ready : result handshake
//   out_result, out_tag   : selected product half and its tag
// -----------------------------------------------------------------------------
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSLICE = WIDTH / PP_W;
  localparam int NPROD  = NSLICE * NSLICE;
  localparam int PROD_W = 2 * PP_W;

  generate
    if (!width_is_legal(WIDTH)) begin : g_illegal_width
      $error("nios2_mult_pipe: WIDTH must be 16, 32, 48 or 64");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic stall_s;
  logic in_ready_s;
  logic accept_s;
  logic pp_en_s;

  // S1 state
  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] s1_a_d, s1_a_q;
  logic [WIDTH-1:0] s1_b_d, s1_b_q;
  mult_mode_e       s1_mode_d, s1_mode_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

  // S2 state (partial products live inside the pp16 instances)
  logic             s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] s2_a_d, s2_a_q;
  logic [WIDTH-1:0] s2_b_d, s2_b_q;
  mult_mode_e       s2_mode_d, s2_mode_q;
  logic [TAG_W-1:0] s2_tag_d, s2_tag_q;
  logic [NPROD*PROD_W-1:0] pp_flat_s;

  // S3 / output state
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_result_d, out_result_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  // S3 combinational datapath
  logic [2*WIDTH-1:0] term_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   hi_uu_s;
  logic [WIDTH-1:0]   hi_su_s;
  logic [WIDTH-1:0]   hi_ss_s;
  logic [WIDTH-1:0]   sel_s;

  // Global stall and input acceptance; nothing is accepted during reset or flush.
  always_comb begin
    stall_s    = out_valid_q && !out_ready;
    in_ready_s = reset_n && !flush && !stall_s;
    accept_s   = in_valid && in_ready_s;
    pp_en_s    = !stall_s;
  end

  // Stage valid bits: flush clears, stall holds, otherwise shift forward.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (stall_s) begin
      s1_valid_d  = s1_valid_q;
      s2_valid_d  = s2_valid_q;
      out_valid_d = out_valid_q;
    end else begin
      s1_valid_d  = accept_s;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
    end
  end

  // S1 data: capture the offered operation only on a handshake.
  always_comb begin
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_mode_d = s1_mode_q;
    s1_tag_d  = s1_tag_q;
    if (accept_s) begin
      s1_a_d    = in_src1;
      s1_b_d    = in_src2;
      s1_mode_d = mult_mode_e'(in_mode);
      s1_tag_d  = in_tag;
    end else begin
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_mode_d = s1_mode_q;
      s1_tag_d  = s1_tag_q;
    end
  end

  // S2 side data: full operands travel along because the signed corrections
  // in S3 subtract whole operands from the unsigned high half.
  always_comb begin
    s2_a_d    = s2_a_q;
    s2_b_d    = s2_b_q;
    s2_mode_d = s2_mode_q;
    s2_tag_d  = s2_tag_q;
    if (!stall_s) begin
      s2_a_d    = s1_a_q;
      s2_b_d    = s1_b_q;
      s2_mode_d = s1_mode_q;
      s2_tag_d  = s1_tag_q;
    end else begin
      s2_a_d    = s2_a_q;
      s2_b_d    = s2_b_q;
      s2_mode_d = s2_mode_q;
      s2_tag_d  = s2_tag_q;
    end
  end

  // One registered 16x16 multiplier per (A slice, B slice) pair.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_row
    for (genvar gj = 0; gj < NSLICE; gj++) begin : g_col
      nios2_mult_pp16 u_pp (
        .clk (clk),
        .en  (pp_en_s),
        .a   (s1_a_q[gi*PP_W +: PP_W]),
        .b   (s1_b_q[gj*PP_W +: PP_W]),
        .p   (pp_flat_s[(gi*NSLICE+gj)*PROD_W +: PROD_W])
      );
    end
  end

  // Sum the partial products, each weighted by 2^(16*(i+j)).
  always_comb begin
    prod_s = '0;
    term_s = '0;
    for (int i = 0; i < NSLICE; i++) begin
      for (int j = 0; j < NSLICE; j++) begin
        term_s = '0;
        term_s[PROD_W-1:0] = pp_flat_s[(i*NSLICE+j)*PROD_W +: PROD_W];
        prod_s = prod_s + (term_s << (PP_W*(i+j)));
      end
    end
  end

  // Signed high halves derived from the unsigned one: a negative A adds
  // -2^W*B to the product, a negative B adds -2^W*A (the 2^2W cross term
  // vanishes modulo 2^2W).
  always_comb begin
    hi_uu_s = prod_s[2*WIDTH-1:WIDTH];
    hi_su_s = hi_uu_s - (s2_a_q[WIDTH-1] ? s2_b_q : {WIDTH{1'b0}});
    hi_ss_s = hi_su_s - (s2_b_q[WIDTH-1] ? s2_a_q : {WIDTH{1'b0}});
    case (s2_mode_q)
      MODE_LO:    sel_s = prod_s[WIDTH-1:0];
      MODE_HI_SS: sel_s = hi_ss_s;
      MODE_HI_SU: sel_s = hi_su_s;
      MODE_HI_UU: sel_s = hi_uu_s;
      default:    sel_s = prod_s[WIDTH-1:0];
    endcase
  end

  // Output data: frozen during a stall so the consumer sees a stable result.
  always_comb begin
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (!stall_s) begin
      out_result_d = sel_s;
      out_tag_d    = s2_tag_q;
    end else begin
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
    end
  end

  // Valid bits: the only state that sees reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data registers: intentionally un-reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    s1_a_q       <= s1_a_d;
    s1_b_q       <= s1_b_d;
    s1_mode_q    <= s1_mode_d;
    s1_tag_q     <= s1_tag_d;
    s2_a_q       <= s2_a_d;
    s2_b_q       <= s2_b_d;
    s2_mode_q    <= s2_mode_d;
    s2_tag_q     <= s2_tag_d;
    out_result_q <= out_result_d;
    out_tag_q    <= out_tag_d;
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule : nios2_mult_pipe
